mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one native-interface memory/IO port among N_CORES
//  PicoRV32 masters (valid/ready, addr/wdata/wstrb/rdata). It sits between the core
//  array and the SoC memory/peripheral decoder.
//  One transaction is in flight at a time, with fair rotation between cores.
//  A watchdog completes a transaction that is never acknowledged, so a stuck slave
//  cannot hang the SoC.
// PARAMETERS
//  N_CORES    4    number of requesting cores (2..8)
//  TIMEOUT    255  cycles to wait for mem_ready before a forced error completion (1..65535)
//  ERR_RDATA  32'hDEADBEEF  read data returned on a timed-out transaction
// PORTS
//  clk          in   1          clock
//  resetn       in   1          synchronous, active-low reset
//  core_valid   in   N_CORES    per-core request; held until its core_ready pulse
//  core_addr    in   32*N_CORES per-core byte address, core i at [32*i+31 -: 32]
//  core_wdata   in   32*N_CORES per-core write data
//  core_wstrb   in   4*N_CORES  per-core byte strobes; 0 = read
//  core_ready   out  N_CORES    one-cycle completion pulse to the granted core
//  core_rdata   out  32*N_CORES per-core read data; valid while core_ready[i] = 1
//  mem_valid    out  1          downstream request
//  mem_addr     out  32         downstream address (registered)
//  mem_wdata    out  32         downstream write data (registered)
//  mem_wstrb    out  4          downstream strobes (registered)
//  mem_ready    in   1          downstream acknowledge; one-cycle pulse
//  mem_rdata    in   32         downstream read data; valid with mem_ready
//  grant_id     out  3          index of the core owning the current or last transaction
//  timeout_err  out  1          one-cycle pulse when a transaction is force-completed
// BEHAVIOUR
//  - Reset (resetn = 0 at a clk edge)
//    - Outputs: mem_valid, core_ready, timeout_err, grant_id, mem_addr/wdata/wstrb,
//      core_rdata all 0.
//    - Internal: state = IDLE, rr_ptr = 0, wdog = 0.
//    - Reset mid-transaction abandons it. No core_ready is issued.
//  - FSM states: IDLE and BUSY.
//  - IDLE
//    - If |core_valid, select g = the first i with core_valid[i] = 1, scanning rr_ptr,
//      rr_ptr+1, ... modulo N_CORES.
//    - At that edge: latch core g's addr/wdata/wstrb into mem_*, set mem_valid = 1,
//      grant_id = g, wdog = 0, state -> BUSY.
//    - mem_ready seen in IDLE is ignored.
//  - BUSY
//    - mem_valid = 1 and mem_* stay stable; wdog increments each cycle.
//    - If mem_ready = 1:
//      - core_rdata[g] <= mem_rdata, core_ready[g] <= 1 (one cycle).
//      - mem_valid <= 0, rr_ptr <= (g+1) mod N_CORES, state -> IDLE.
//    - Else, if wdog == TIMEOUT-1:
//      - Same completion, but core_rdata[g] <= ERR_RDATA and timeout_err <= 1.
//    - mem_ready takes priority over the timeout when both fall on the same cycle.
//  - Latency
//    - Request seen in IDLE at edge t -> mem_valid high from t+1.
//    - mem_ready at edge k -> core_ready[g] high in cycle k+1.
//    - Minimum 2-cycle transaction, then 1 IDLE cycle before the next grant.
//  - Only the granted core's core_ready/core_rdata change; other cores' core_rdata
//    hold their previous value.
//  - core_valid[g] dropping during BUSY is a protocol violation. The arbiter still
//    completes the transaction and pulses core_ready[g].
//  - Fairness: with all cores requesting continuously, grants rotate 0,1,2,3,0,...
//    No core waits more than N_CORES-1 transactions.
//  - wdog width = clog2(TIMEOUT+1); it never wraps.
// TESTING
//  1. Reset: resetn=0 for 4 cycles with core_valid=4'hF -> mem_valid=0, core_ready=0,
//     grant_id=0 throughout.
//  2. Single read: core2 valid, addr=0x40, wstrb=0; mem_ready 2 cycles after mem_valid
//     with rdata=0x12345678 -> mem_addr=0x40; core_ready=4'b0100 for one cycle;
//     core_rdata[2]=0x12345678.
//  3. Contention: core_valid=4'hF from reset, mem_ready 1 cycle after each mem_valid ->
//     grant_id sequence 0,1,2,3,0,1; each core_ready bit pulses once per 4 transactions.
//  4. Write: core1 addr=0x1000_0000, wdata=0xA5, wstrb=4'b0001 -> mem_wstrb=4'b0001,
//     mem_wdata=0xA5 stable until mem_ready; core_ready[1] pulses.
//  5. Timeout: TIMEOUT=8, core3 read, mem_ready never asserted -> after 8 BUSY cycles,
//     core_ready[3]=1, core_rdata[3]=0xDEADBEEF, timeout_err=1, mem_valid=0.
//  6. Mid-op reset: resetn=0 while BUSY for core0 -> next cycle mem_valid=0, no
//     core_ready; after release, core1 request is granted first (rr_ptr=0, core0 idle).

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one native valid/ready memory port among N_CORES masters.
// One transaction in flight at a time; a watchdog force-completes unacknowledged requests.
module mem_rr_arbiter #(
  parameter int          N_CORES   = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CORES-1:0]     core_valid,
  input  logic [32*N_CORES-1:0]  core_addr,
  input  logic [32*N_CORES-1:0]  core_wdata,
  input  logic [4*N_CORES-1:0]   core_wstrb,
  output logic [N_CORES-1:0]     core_ready,
  output logic [32*N_CORES-1:0]  core_rdata,
  output logic                   mem_valid,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_wstrb,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  output logic [2:0]             grant_id,
  output logic                   timeout_err
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   grant_reg;
  logic [WW-1:0]   wdog_reg;
  logic [31:0]     rdata_reg [N_CORES];

  logic [31:0]     addr_arr  [N_CORES];
  logic [31:0]     wdata_arr [N_CORES];
  logic [3:0]      wstrb_arr [N_CORES];
  logic [PW-1:0]   cand_idx  [N_CORES];
  logic [N_CORES-1:0] cand_req;

  logic [PW-1:0]   sel_idx;
  logic            sel_found;
  logic [PW-1:0]   next_ptr;
  logic            done;

  // Candidate k is the core k positions after the rotation pointer, wrapped modulo N_CORES.
  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
      logic [PW:0] sum_w;
      assign addr_arr[gi]   = core_addr[32*gi +: 32];
      assign wdata_arr[gi]  = core_wdata[32*gi +: 32];
      assign wstrb_arr[gi]  = core_wstrb[4*gi +: 4];
      assign core_rdata[32*gi +: 32] = rdata_reg[gi];
      assign sum_w          = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
      assign cand_idx[gi]   = (sum_w >= (PW+1)'(N_CORES)) ?
                              PW'(sum_w - (PW+1)'(N_CORES)) : sum_w[PW-1:0];
      assign cand_req[gi]   = core_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  assign next_ptr = (grant_reg == PW'(N_CORES - 1)) ? '0 : grant_reg + 1'b1;
  // The acknowledge wins over the watchdog when both land on the same cycle.
  assign done     = mem_ready || (wdog_reg == WW'(TIMEOUT - 1));
  assign grant_id = 3'(grant_reg);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      grant_reg   <= '0;
      wdog_reg    <= '0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      core_ready  <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N_CORES; i++) rdata_reg[i] <= '0;
    end else begin
      core_ready  <= '0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            mem_addr  <= addr_arr[sel_idx];
            mem_wdata <= wdata_arr[sel_idx];
            mem_wstrb <= wstrb_arr[sel_idx];
            mem_valid <= 1'b1;
            grant_reg <= sel_idx;
            wdog_reg  <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            core_ready[grant_reg] <= 1'b1;
            rdata_reg[grant_reg]  <= mem_ready ? mem_rdata : ERR_RDATA;
            timeout_err           <= !mem_ready;
            mem_valid             <= 1'b0;
            rr_ptr_reg            <= next_ptr;
            state_reg             <= IDLE;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of rotation, latency and watchdog completion.
module tb_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N-1:0]      core_valid;
  logic [32*N-1:0]   core_addr;
  logic [32*N-1:0]   core_wdata;
  logic [4*N-1:0]    core_wstrb;
  logic [N-1:0]      core_ready;
  logic [32*N-1:0]   core_rdata;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [2:0]        grant_id;
  logic              timeout_err;

  mem_rr_arbiter #(.N_CORES(N), .TIMEOUT(TO), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .core_valid(core_valid), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_wstrb(core_wstrb), .core_ready(core_ready), .core_rdata(core_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each core's pending request, the last data each core received, and the
  // core that has first claim on the next grant.
  bit          v [N];
  logic [31:0] a [N];
  logic [31:0] w [N];
  logic [3:0]  s [N];
  logic [31:0] model_rd [N];
  int          exp_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      core_valid[i]          = v[i];
      core_addr[32*i +: 32]  = a[i];
      core_wdata[32*i +: 32] = w[i];
      core_wstrb[4*i +: 4]   = s[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (v[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    v[i] = 1'b1;
    a[i] = $urandom;
    w[i] = $urandom;
    s[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
  endtask

  // One transaction: grant on the next edge, slave answers after lat busy cycles
  // (lat >= TO means it never answers and the watchdog must complete it).
  task automatic txn(input int lat, input logic [31:0] rd, input bit keep);
    int          g;
    int          comp;
    bit          to;
    logic [31:0] exp_rd;
    g = pick();
    @(posedge clk); #1;
    chk("grant_mem_valid", 32'(mem_valid), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("grant_addr", mem_addr, a[g]);
    chk("grant_wdata", mem_wdata, w[g]);
    chk("grant_wstrb", 32'(mem_wstrb), 32'(s[g]));
    chk("grant_no_ready", 32'(core_ready), 32'd0);
    to   = (lat >= TO);
    comp = to ? TO - 1 : lat;
    for (int c = 0; c <= comp; c++) begin
      if (!to && c == lat) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (c < comp) begin
        chk("busy_mem_valid", 32'(mem_valid), 32'd1);
        chk("busy_no_ready", 32'(core_ready), 32'd0);
        chk("busy_addr", mem_addr, a[g]);
        chk("busy_wdata", mem_wdata, w[g]);
        chk("busy_timeout", 32'(timeout_err), 32'd0);
      end
    end
    exp_rd      = to ? 32'hDEADBEEF : rd;
    model_rd[g] = exp_rd;
    chk("done_ready", 32'(core_ready), 32'(1 << g));
    chk("done_timeout", 32'(timeout_err), 32'(to));
    chk("done_mem_valid", 32'(mem_valid), 32'd0);
    chk("done_grant_id", 32'(grant_id), 32'(g));
    for (int i = 0; i < N; i++) chk("done_rdata", core_rdata[32*i +: 32], model_rd[i]);
    $display("txn core=%0d lat=%0d timeout=%0d rdata=%08h", g, lat, to, exp_rd);
    exp_ptr = (g + 1) % N;
    if (keep) new_req(g);
    else      v[g] = 1'b0;
    apply();
  endtask

  initial begin
    resetn    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    exp_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      new_req(i);
      model_rd[i] = '0;
    end
    apply();

    // Reset held with every core requesting.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_core_ready", 32'(core_ready), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
    end
    chk("rst_rdata", core_rdata[31:0], 32'd0);
    resetn = 1'b1;

    // Contention: all cores request continuously, immediate acknowledge.
    for (int t = 0; t < 6; t++) txn(0, $urandom, 1'b1);

    // Acknowledge while idle must be ignored.
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    apply();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("idle_ack_mem_valid", 32'(mem_valid), 32'd0);
    chk("idle_ack_core_ready", 32'(core_ready), 32'd0);

    // Single read from core 2.
    v[2] = 1'b1; a[2] = 32'h40; w[2] = 32'h0; s[2] = 4'h0;
    apply();
    txn(1, 32'h12345678, 1'b0);

    // Write from core 1.
    v[1] = 1'b1; a[1] = 32'h1000_0000; w[1] = 32'hA5; s[1] = 4'b0001;
    apply();
    txn(3, $urandom, 1'b0);

    // Unanswered read from core 3 is completed by the watchdog.
    v[3] = 1'b1; a[3] = $urandom; w[3] = 32'h0; s[3] = 4'h0;
    apply();
    txn(100, 32'h0, 1'b0);

    // Reset while core 0 is being served abandons the transaction.
    v[0] = 1'b1; a[0] = $urandom; w[0] = $urandom; s[0] = 4'h0;
    apply();
    @(posedge clk); #1;
    chk("midrst_grant_valid", 32'(mem_valid), 32'd1);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    v[0] = 1'b0;
    new_req(1);
    apply();
    @(posedge clk); #1;
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_core_ready", 32'(core_ready), 32'd0);
    chk("midrst_grant_id0", 32'(grant_id), 32'd0);
    for (int i = 0; i < N; i++) model_rd[i] = '0;
    exp_ptr = 0;
    resetn  = 1'b1;
    txn(2, $urandom, 1'b0);

    // Randomized traffic with mixed latencies, including watchdog completions.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) new_req(i);
      end
      if (pick() < 0) new_req($urandom_range(0, N - 1));
      apply();
      txn($urandom_range(0, 10), $urandom, $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
